// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter for instruction fetch and MEM stage (optional IO_WAIT_EN IO write stall)
module mem_arbiter #(
    parameter int          ADDR_W     = 32,
    parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              jump_enable,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [31:0] rbuf;
    logic [31:0] wbuf;
    logic [1:0]  io_page;
    logic        wr_q;
    logic        io_hold;
    logic [2:0]  len_n;
    logic [5:0]  shamt;
    logic [31:0] rbuf_next;

`ifdef IO_WAIT_EN
    assign io_hold = (state == MEM_WR) && (io_page == IO_BASE_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full ^ (io_page == IO_BASE_HI);
    assign io_hold   = 1'b0;
`endif

    assign ram_wr = wr_q & rdy_in & ~io_hold;

    // Byte k of a read arrives two edges after its address was issued, i.e. while cnt == k+1.
    always_comb begin
        len_n     = (mem_len == 3'd1 || mem_len == 3'd2) ? mem_len : 3'd4;
        shamt     = {cnt - 3'd1, 3'b000};
        rbuf_next = rbuf | ({24'b0, ram_din} << shamt);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            rbuf      <= 32'd0;
            wbuf      <= 32'd0;
            io_page   <= 2'd0;
            wr_q      <= 1'b0;
            ram_a     <= '0;
            ram_dout  <= 8'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done-pulse check leaves a bubble so requesters may drop req on done.
                    if (!if_done && !mem_done) begin
                        if (mem_req) begin
                            ram_a   <= mem_addr;
                            io_page <= mem_addr[17:16];
                            cnt     <= 3'd0;
                            len     <= len_n;
                            rbuf    <= 32'd0;
                            if (mem_we) begin
                                state    <= MEM_WR;
                                wr_q     <= 1'b1;
                                ram_dout <= mem_wdata[7:0];
                                wbuf     <= mem_wdata >> 8;
                            end else begin
                                state <= MEM_RD;
                            end
                        end else if (if_req && !jump_enable) begin
                            state <= IF_RD;
                            ram_a <= if_addr;
                            cnt   <= 3'd0;
                            len   <= 3'd4;
                            rbuf  <= 32'd0;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && jump_enable) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 < len)
                            ram_a <= ram_a + ADDR_ONE;
                        if (cnt != 3'd0)
                            rbuf <= rbuf_next;
                        if (cnt == len) begin
                            state <= IDLE;
                            if (state == IF_RD) begin
                                if_data <= rbuf_next;
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= rbuf_next;
                                mem_done  <= 1'b1;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (!io_hold) begin
                        if (cnt + 3'd1 < len) begin
                            cnt      <= cnt + 3'd1;
                            ram_a    <= ram_a + ADDR_ONE;
                            ram_dout <= wbuf[7:0];
                            wbuf     <= wbuf >> 8;
                        end else begin
                            wr_q     <= 1'b0;
                            mem_done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
